pipe_hazard_ctrl: RTL and testbench

- Central pipeline control unit for the 5-stage Y86-64 pipeline (F/D/E/M/W).
- Generates per-stage stall/bubble controls for load/use, ret and mispredicted-jump hazards.
- Sequences exception/halt shutdown so the writeback register-file update freezes on the first non-AOK status.
- Holds the machine in HALTED until reset.

---
 rtl/pipe_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central control unit for the 5-stage Y86-64 pipeline.
// Generates the per-stage stall and bubble controls for load/use, ret and
// mispredicted-jump hazards. It also sequences exception/halt shutdown
// (RUN -> DRAIN -> HALTED) and holds HALTED until reset.
// Optional feature macro: PIPE_CTRL_PERF_EN adds saturating performance
// counters (cyc_cnt, stall_cnt, bubble_cnt) that are CNT_W bits wide.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] D_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_icode,
  input  logic [3:0] E_dstM,
  input  logic       e_cnd,
  input  logic [3:0] M_icode,
  input  logic [1:0] m_stat,
  input  logic [1:0] W_stat,
  output logic       F_stall,
  output logic       D_stall,
  output logic       D_bubble,
  output logic       E_bubble,
  output logic       M_bubble,
  output logic       W_stall,
  output logic       halted,
  output logic [1:0] exc_stat
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_POP   = 4'hB;
  localparam logic [3:0] R_NONE  = 4'hF;
  localparam logic [1:0] S_AOK   = 2'b00;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

  state_e     state_q, state_d;
  logic       halted_q, halted_d;
  logic [1:0] exc_stat_q, exc_stat_d;

  logic loaduse_s;
  logic mispredict_s;
  logic ret_p_s;
  logic m_bad_s;
  logic w_bad_s;

  // Hazard detection terms from the decode/execute/memory stage fields.
  always_comb begin
    loaduse_s    = ((E_icode == I_MRMOV) || (E_icode == I_POP)) &&
                   (E_dstM != R_NONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    mispredict_s = (E_icode == I_JXX) && !e_cnd;
    ret_p_s      = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    m_bad_s      = (m_stat != S_AOK);
    w_bad_s      = (W_stat != S_AOK);
  end

  // Per-stage stall/bubble controls, combinational from state and inputs.
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    if (!rst_n) begin
      // Reset flushes D/E/M with NOPs and lets fetch run.
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          F_stall  = loaduse_s | ret_p_s;
          // A mispredict squashes D, so it must not also be held.
          D_stall  = loaduse_s & ~mispredict_s;
          D_bubble = mispredict_s | (ret_p_s & ~loaduse_s);
          E_bubble = mispredict_s | loaduse_s;
          M_bubble = m_bad_s | w_bad_s;
          W_stall  = w_bad_s;
        end
        ST_DRAIN: begin
          F_stall  = 1'b1;
          D_stall  = 1'b1;
          E_bubble = 1'b1;
          M_bubble = 1'b1;
          W_stall  = w_bad_s;
        end
        ST_HALTED: begin
          F_stall  = 1'b1;
          D_stall  = 1'b1;
          E_bubble = 1'b1;
          M_bubble = 1'b1;
          W_stall  = 1'b1;
        end
        default: begin
          // Unreachable encoding: freeze everything like HALTED.
          F_stall  = 1'b1;
          D_stall  = 1'b1;
          E_bubble = 1'b1;
          M_bubble = 1'b1;
          W_stall  = 1'b1;
        end
      endcase
    end
  end

  // Shutdown sequencing: the writeback status wins over the memory status.
  always_comb begin
    state_d    = state_q;
    halted_d   = halted_q;
    exc_stat_d = exc_stat_q;
    case (state_q)
      ST_RUN: begin
        if (w_bad_s) begin
          state_d    = ST_HALTED;
          halted_d   = 1'b1;
          exc_stat_d = W_stat;
        end else if (m_bad_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (w_bad_s) begin
          state_d    = ST_HALTED;
          halted_d   = 1'b1;
          exc_stat_d = W_stat;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      halted_q   <= 1'b0;
      exc_stat_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      halted_q   <= halted_d;
      exc_stat_q <= exc_stat_d;
    end
  end

  assign halted   = halted_q;
  assign exc_stat = exc_stat_q;

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating counters that advance only while the machine is in RUN.
  always_comb begin
    cyc_cnt_d    = cyc_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (state_q == ST_RUN) begin
      if (cyc_cnt_q != CNT_MAX) begin
        cyc_cnt_d = cyc_cnt_q + CNT_ONE;
      end else begin
        cyc_cnt_d = cyc_cnt_q;
      end
      if (F_stall && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      if ((D_bubble || E_bubble) && (bubble_cnt_q != CNT_MAX)) begin
        bubble_cnt_d = bubble_cnt_q + CNT_ONE;
      end else begin
        bubble_cnt_d = bubble_cnt_q;
      end
    end else begin
      cyc_cnt_d    = cyc_cnt_q;
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_cnt_q    <= {CNT_W{1'b0}};
      stall_cnt_q  <= {CNT_W{1'b0}};
      bubble_cnt_q <= {CNT_W{1'b0}};
    end else begin
      cyc_cnt_q    <= cyc_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign cyc_cnt    = cyc_cnt_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed hazard and shutdown sequences,
// followed by randomized stimulus checked against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int CW = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic       e_cnd;
  logic [1:0] m_stat, W_stat;
  logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
  logic [1:0] exc_stat;
`ifdef PIPE_CTRL_PERF_EN
  logic [CW-1:0] cyc_cnt, stall_cnt, bubble_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: 0 = running, 1 = draining, 2 = halted.
  int mode;
  int m_exc;
  int m_cyc, m_stl, m_bub;

  pipe_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .halted(halted), .exc_stat(exc_stat)
`ifdef PIPE_CTRL_PERF_EN
    , .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Neutral pipeline contents: NOPs everywhere, no registers, AOK status.
  task automatic idle_inputs();
    rst_n = 1'b1;
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
    d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF;
    e_cnd = 1'b1; m_stat = 2'b00; W_stat = 2'b00;
  endtask

  // Inputs are set just after a negedge; check mid-cycle, then advance the model.
  task automatic run_cycle();
    bit ld, mp, rp, ex_f, ex_ds, ex_db, ex_eb, ex_mb, ex_w;
    int cmax;
    cmax = (1 << CW) - 1;
    #1;
    ld = ((E_icode == 4'h5) || (E_icode == 4'hB)) && (E_dstM != 4'hF) &&
         ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    mp = (E_icode == 4'h7) && !e_cnd;
    rp = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
    if (!rst_n) begin
      {ex_f, ex_ds, ex_db, ex_eb, ex_mb, ex_w} = 6'b001110;
    end else if (mode == 2) begin
      {ex_f, ex_ds, ex_db, ex_eb, ex_mb, ex_w} = 6'b110111;
    end else if (mode == 1) begin
      {ex_f, ex_ds, ex_db, ex_eb, ex_mb} = 5'b11011;
      ex_w = (W_stat != 2'b00);
    end else begin
      ex_f  = ld || rp;
      ex_db = mp || (rp && !ld);
      ex_ds = ld && !mp;
      ex_eb = mp || ld;
      ex_mb = (m_stat != 2'b00) || (W_stat != 2'b00);
      ex_w  = (W_stat != 2'b00);
    end
    check_val("F_stall",  F_stall,  ex_f);
    check_val("D_stall",  D_stall,  ex_ds);
    check_val("D_bubble", D_bubble, ex_db);
    check_val("E_bubble", E_bubble, ex_eb);
    check_val("M_bubble", M_bubble, ex_mb);
    check_val("W_stall",  W_stall,  ex_w);
    check_val("halted",   halted,   (mode == 2));
    check_val("exc_stat", exc_stat, m_exc);
    check_val("no_ds_db", D_stall & D_bubble, 0);
`ifdef PIPE_CTRL_PERF_EN
    check_val("cyc_cnt",    cyc_cnt,    m_cyc);
    check_val("stall_cnt",  stall_cnt,  m_stl);
    check_val("bubble_cnt", bubble_cnt, m_bub);
`endif
    @(posedge clk);
    if (!rst_n) begin
      mode = 0; m_exc = 0; m_cyc = 0; m_stl = 0; m_bub = 0;
    end else begin
      if (mode == 0) begin
        if (m_cyc < cmax) m_cyc++;
        if (ex_f && m_stl < cmax) m_stl++;
        if ((ex_db || ex_eb) && m_bub < cmax) m_bub++;
      end
      if (mode != 2 && W_stat != 2'b00) begin
        mode = 2; m_exc = W_stat;
      end else if (mode == 0 && m_stat != 2'b00) begin
        mode = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    run_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    mode = 0; m_exc = 0; m_cyc = 0; m_stl = 0; m_bub = 0;
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();
    check_val("rst_halted", halted, 0);
    check_val("rst_exc", exc_stat, 0);

    // Load/use hit, then a miss on the same load.
    idle_inputs(); E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    #1; check_val("lu_F", F_stall, 1); check_val("lu_Ds", D_stall, 1);
    check_val("lu_Db", D_bubble, 0);
    run_cycle();
    idle_inputs(); E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h2;
    #1; check_val("lu_miss", {F_stall, D_stall, D_bubble, E_bubble}, 0);
    run_cycle();

    // ret travelling D -> E -> M, then gone.
    for (int k = 0; k < 4; k++) begin
      idle_inputs();
      if (k == 0) D_icode = 4'h9;
      if (k == 1) E_icode = 4'h9;
      if (k == 2) M_icode = 4'h9;
      #1; check_val("ret_F", F_stall, (k < 3)); check_val("ret_Db", D_bubble, (k < 3));
      run_cycle();
    end

    // Mispredicted and correctly predicted jump.
    idle_inputs(); E_icode = 4'h7; e_cnd = 1'b0;
    #1; check_val("mp", {F_stall, D_bubble, E_bubble}, 3'b011);
    run_cycle();
    idle_inputs(); E_icode = 4'h7; e_cnd = 1'b1;
    #1; check_val("mp_taken", {F_stall, D_bubble, E_bubble}, 0);
    run_cycle();

    // Exception: memory status first, then writeback; sticky HALTED.
    idle_inputs(); m_stat = 2'b10;
    #1; check_val("exc_Mb", M_bubble, 1);
    run_cycle();
    idle_inputs(); W_stat = 2'b10;
    run_cycle();
    idle_inputs();
    for (int k = 0; k < 5; k++) begin
      check_val("halt_exc", exc_stat, 2'b10);
      check_val("halt_W", W_stall, 1);
      run_cycle();
    end

    // Reset while halted.
    idle_inputs(); rst_n = 1'b0;
    #1; check_val("rst_forced", {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}, 6'b001110);
    run_cycle();
    idle_inputs();
    check_val("rst2_halted", halted, 0);
    check_val("rst2_exc", exc_stat, 0);

    // Simultaneous memory and writeback faults go straight to HALTED.
    idle_inputs(); m_stat = 2'b11; W_stat = 2'b01;
    run_cycle();
    idle_inputs();
    check_val("simul_halt", halted, 1);
    check_val("simul_exc", exc_stat, 2'b01);
    run_cycle();

    // Ten RUN cycles with exactly one load/use.
    do_reset();
`ifdef PIPE_CTRL_PERF_EN
    check_val("perf_clr", cyc_cnt, 0);
`endif
    for (int k = 0; k < 10; k++) begin
      idle_inputs();
      if (k == 4) begin E_icode = 4'hB; E_dstM = 4'h6; d_srcB = 4'h6; end
      run_cycle();
    end
`ifdef PIPE_CTRL_PERF_EN
    check_val("perf_cyc10", cyc_cnt, 10);
    check_val("perf_stl1", stall_cnt, 1);
`endif

    // Randomized stimulus.
    for (int k = 0; k < 3000; k++) begin
      logic [3:0] r;
      rst_n   = ($urandom_range(0, 199) != 0);
      D_icode = 4'($urandom_range(0, 11));
      E_icode = 4'($urandom_range(0, 11));
      M_icode = 4'($urandom_range(0, 11));
      r       = 4'($urandom_range(0, 15));
      E_dstM  = ($urandom_range(0, 3) == 0) ? 4'hF : r;
      d_srcA  = ($urandom_range(0, 2) == 0) ? r : 4'($urandom_range(0, 15));
      d_srcB  = ($urandom_range(0, 2) == 0) ? r : 4'($urandom_range(0, 15));
      e_cnd   = 1'($urandom_range(0, 1));
      m_stat  = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      W_stat  = ($urandom_range(0, 79) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (mode == 2 && $urandom_range(0, 9) == 0) rst_n = 1'b0;
      run_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
